// File: rtl/axi_wr_responder_if.sv
// AW/W/B signal bundle for axi_wr_responder; buser only exists when WR_RESP_BUSER_EN is defined.
interface axi_wr_responder_if #(
  parameter int DEPTH         = 8,
  parameter int PID_WIDTH     = 4,
  parameter int PAWUSER_WIDTH = 2
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic                     awvalid;
  logic                     awready;
  logic [PID_WIDTH-1:0]     awid;
  logic [PAWUSER_WIDTH-1:0] awuser;
  logic                     wvalid;
  logic                     wready;
  logic                     wlast;
  logic                     bvalid;
  logic                     bready;
  logic [PID_WIDTH-1:0]     bid;
  logic [1:0]               bresp;
  logic [CW-1:0]            outstanding;
`ifdef WR_RESP_BUSER_EN
  logic [PAWUSER_WIDTH-1:0] buser;
`endif

  modport slave (
    input  awvalid, awid, awuser, wvalid, wlast, bready,
    output awready, wready, bvalid, bid, bresp, outstanding
`ifdef WR_RESP_BUSER_EN
    , output buser
`endif
  );

  modport master (
    output awvalid, awid, awuser, wvalid, wlast, bready,
    input  awready, wready, bvalid, bid, bresp, outstanding
`ifdef WR_RESP_BUSER_EN
    , input buser
`endif
  );
endinterface

// File: rtl/axi_wr_responder.sv
// Subordinate-side AXI write responder: in-order AW queue, W burst completion, delayed in-order B.
// Optional macro WR_RESP_BUSER_EN stores awuser per entry and returns it on buser.
module axi_wr_responder #(
  parameter int DEPTH         = 8,
  parameter int PID_WIDTH     = 4,
  parameter int PAWUSER_WIDTH = 2,
  parameter int RESP_DELAY    = 2
) (
  input  logic               clk,
  input  logic               rst,
  axi_wr_responder_if.slave  bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [PID_WIDTH-1:0]     id;
`ifdef WR_RESP_BUSER_EN
    logic [PAWUSER_WIDTH-1:0] user;
`endif
    logic                     done;
  } entry_t;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  entry_t        q [DEPTH];
  logic [PW-1:0] aw_ptr, d_ptr, r_ptr;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] pend;        // addresses whose burst has not yet seen wlast
  logic          live;
  state_t        state, state_nx;
  logic [3:0]    cnt, cnt_nx;
  logic          bvalid;
  logic          aw_fire, wl_fire, b_fire;

`ifndef WR_RESP_BUSER_EN
  logic unused_awuser;
  assign unused_awuser = ^bus.awuser;
`endif

  assign bus.awready     = live && (outstanding < CW'(DEPTH));
  // pend rather than d_ptr != aw_ptr, since the two pointers also meet when the queue is full
  assign bus.wready      = (pend != '0);
  assign aw_fire         = bus.awvalid && bus.awready;
  assign wl_fire         = bus.wvalid && bus.wready && bus.wlast;
  assign b_fire          = bvalid && bus.bready;

  assign bus.bvalid      = bvalid;
  assign bus.bid         = bvalid ? q[r_ptr].id : '0;
  assign bus.bresp       = 2'b00;
  assign bus.outstanding = outstanding;
`ifdef WR_RESP_BUSER_EN
  assign bus.buser       = bvalid ? q[r_ptr].user : '0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) q[i] <= '0;
      aw_ptr      <= '0;
      d_ptr       <= '0;
      r_ptr       <= '0;
      outstanding <= '0;
      pend        <= '0;
      live        <= 1'b0;
    end else begin
      live <= 1'b1;
      if (aw_fire) begin
        q[aw_ptr].id   <= bus.awid;
`ifdef WR_RESP_BUSER_EN
        q[aw_ptr].user <= bus.awuser;
`endif
        q[aw_ptr].done <= 1'b0;
        aw_ptr         <= aw_ptr + 1'b1;
      end
      if (wl_fire) begin
        q[d_ptr].done <= 1'b1;
        d_ptr         <= d_ptr + 1'b1;
      end
      if (b_fire) begin
        q[r_ptr].done <= 1'b0;
        r_ptr         <= r_ptr + 1'b1;
      end
      outstanding <= outstanding + CW'(aw_fire) - CW'(b_fire);
      pend        <= pend + CW'(aw_fire) - CW'(wl_fire);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // WAIT lasts exactly RESP_DELAY cycles: leaving when the count is 1 lands RESP as it reaches 0
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    bvalid   = 1'b0;
    unique case (state)
      S_IDLE: if (q[r_ptr].done) begin
        cnt_nx   = 4'(RESP_DELAY);
        state_nx = (RESP_DELAY == 0) ? S_RESP : S_WAIT;
      end
      S_WAIT: begin
        cnt_nx = cnt - 1'b1;
        if (cnt <= 4'd1) state_nx = S_RESP;
      end
      S_RESP: begin
        bvalid = 1'b1;
        if (bus.bready) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end
endmodule

// File: tb/tb_axi_wr_responder.sv
// Directed bench for axi_wr_responder: expected B responses queued at AW time, popped on each handshake.
module tb_axi_wr_responder;
  localparam int DEPTH = 8;
  localparam int PIDW  = 4;
  localparam int UW    = 2;
  localparam int DLY   = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  axi_wr_responder_if #(.DEPTH(DEPTH), .PID_WIDTH(PIDW), .PAWUSER_WIDTH(UW)) bus ();

  axi_wr_responder #(.DEPTH(DEPTH), .PID_WIDTH(PIDW), .PAWUSER_WIDTH(UW), .RESP_DELAY(DLY)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [PIDW-1:0] id;
    logic [UW-1:0]   user;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   errs    = 0;
  bit   rnd_b   = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rnd_b) bus.bready = 1'($urandom_range(0, 1));
  endtask

  task automatic send_aw(input logic [PIDW-1:0] id, input logic [UW-1:0] user);
    bit ok = 1'b0;
    bus.awvalid = 1'b1;
    bus.awid    = id;
    bus.awuser  = user;
    for (int k = 0; k < 300 && !ok; k++) begin
      @(negedge clk);
      ok = bus.awready;
      if (ok) sb.push_back('{id, user});
      tick();
    end
    if (!ok) chk("aw_timeout", 0, 1);
    bus.awvalid = 1'b0;
  endtask

  task automatic send_w(input logic last);
    bit ok = 1'b0;
    bus.wvalid = 1'b1;
    bus.wlast  = last;
    for (int k = 0; k < 300 && !ok; k++) begin
      @(negedge clk);
      ok = bus.wready;
      tick();
    end
    if (!ok) chk("w_timeout", 0, 1);
    bus.wvalid = 1'b0;
    bus.wlast  = 1'b0;
  endtask

  // returns at the negedge where bvalid was seen high
  task automatic wait_bvalid(input string tag);
    bit seen = 1'b0;
    for (int k = 0; k < 100 && !seen; k++) begin
      @(negedge clk);
      seen = bus.bvalid;
      if (!seen) tick();
    end
    if (!seen) chk(tag, 0, 1);
  endtask

  // returns just after a posedge with outstanding drained
  task automatic wait_idle(input string tag);
    bit seen = 1'b0;
    bus.bready = 1'b1;
    for (int k = 0; k < 400 && !seen; k++) begin
      @(negedge clk);
      seen = (bus.outstanding == 0);
      tick();
    end
    if (!seen) chk(tag, 0, 1);
  endtask

  always @(negedge clk) begin
    if (!rst && bus.bvalid && bus.bready) begin
      if (sb.size() == 0) chk("b_unexpected", 1, 0);
      else begin
        exp_t e;
        e = sb.pop_front();
        chk("bid", bus.bid, e.id);
        chk("bresp", bus.bresp, 0);
`ifdef WR_RESP_BUSER_EN
        chk("buser", bus.buser, e.user);
`endif
      end
    end
  end

  initial begin
    int stale;
    rst = 1'b0;
    bus.awvalid = 1'b0; bus.awid = '0; bus.awuser = '0;
    bus.wvalid = 1'b0; bus.wlast = 1'b0; bus.bready = 1'b0;
    #1 rst = 1'b1;

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_awready", bus.awready, 0);
    chk("rst_wready", bus.wready, 0);
    chk("rst_bvalid", bus.bvalid, 0);
    chk("rst_bid", bus.bid, 0);
    chk("rst_outst", bus.outstanding, 0);
    @(posedge clk); #1 rst = 1'b0;
    tick();
    @(negedge clk);
    chk("post_rst_awready", bus.awready, 1);
    tick();

    // single write, cycle-exact latency
    bus.bready = 1'b1;
    bus.awvalid = 1'b1; bus.awid = 4'h3; bus.awuser = 2'b01;
    sb.push_back('{4'h3, 2'b01});
    @(negedge clk);
    chk("t1_awready", bus.awready, 1);
    tick();
    bus.awvalid = 1'b0; bus.wvalid = 1'b1; bus.wlast = 1'b1;
    @(negedge clk);
    chk("t1_wready", bus.wready, 1);
    chk("t1_outst1", bus.outstanding, 1);
    tick();
    bus.wvalid = 1'b0; bus.wlast = 1'b0;
    for (int c = 2; c <= 6; c++) begin
      @(negedge clk);
      chk($sformatf("t1_bvalid_c%0d", c), bus.bvalid, 32'(c == 5));
      tick();
    end
    @(negedge clk);
    chk("t1_outst0", bus.outstanding, 0);
    tick();

    // fill the queue, then free one slot
    bus.bready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      bus.awvalid = 1'b1; bus.awid = 4'(i); bus.awuser = 2'(i);
      @(negedge clk);
      chk("t2_awready_fill", bus.awready, 1);
      sb.push_back('{4'(i), 2'(i)});
      tick();
    end
    bus.awid = 4'hf;
    @(negedge clk);
    chk("t2_full_awready", bus.awready, 0);
    chk("t2_full_outst", bus.outstanding, DEPTH);
    chk("t2_full_wready", bus.wready, 1);
    tick();
    bus.awvalid = 1'b0;
    send_w(1'b0);
    send_w(1'b1);
    wait_bvalid("t2_bvalid_timeout");
    chk("t2_bv_awready", bus.awready, 0);
    tick();
    bus.bready = 1'b1;
    @(negedge clk);
    chk("t2_pop_cycle_awready", bus.awready, 0);
    tick();
    @(negedge clk);
    chk("t2_after_pop_awready", bus.awready, 1);
    chk("t2_after_pop_outst", bus.outstanding, DEPTH - 1);
    tick();
    for (int i = 1; i < DEPTH; i++) send_w(1'b1);
    wait_idle("t2_drain_timeout");

    // ordering and backpressure
    bus.bready = 1'b0;
    send_aw(4'h5, 2'b00);
    send_aw(4'h2, 2'b01);
    send_aw(4'h9, 2'b11);
    repeat (3) send_w(1'b1);
    wait_bvalid("t3_bvalid_timeout");
    tick();
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("t3_hold_bvalid", bus.bvalid, 1);
      chk("t3_hold_bid", bus.bid, 4'h5);
      tick();
    end
    bus.bready = 1'b1;
    @(negedge clk);
    for (int r = 0; r < 2; r++) begin
      int gap = 0;
      bit seen = 1'b0;
      tick();
      for (int k = 0; k < 50 && !seen; k++) begin
        @(negedge clk);
        seen = bus.bvalid;
        if (!seen) begin gap++; tick(); end
      end
      chk("t3_gap", gap, 1 + DLY);
    end
    tick();
    wait_idle("t3_drain_timeout");

    // W before AW stalls
    bus.wvalid = 1'b1; bus.wlast = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("t4_early_wready", bus.wready, 0);
      tick();
    end
    bus.awvalid = 1'b1; bus.awid = 4'ha; bus.awuser = 2'b10;
    sb.push_back('{4'ha, 2'b10});
    @(negedge clk);
    chk("t4_aw_cycle_wready", bus.wready, 0);
    tick();
    bus.awvalid = 1'b0;
    @(negedge clk);
    chk("t4_next_wready", bus.wready, 1);
    tick();
    bus.wvalid = 1'b0; bus.wlast = 1'b0;
    wait_idle("t4_drain_timeout");

    // pointer wrap with random bready
    rnd_b = 1'b1;
    for (int i = 0; i < 20; i++) begin
      send_aw(4'(i % 16), 2'(i % 4));
      if (i % 3 == 0) send_w(1'b0);
      send_w(1'b1);
    end
    rnd_b = 1'b0;
    wait_idle("t5_drain_timeout");
    chk("t5_sb_empty", sb.size(), 0);

    // reset while a response is pending
    bus.bready = 1'b0;
    send_aw(4'h1, 2'b10);
    send_aw(4'h2, 2'b00);
    send_aw(4'h3, 2'b01);
    repeat (3) send_w(1'b1);
    wait_bvalid("t6_bvalid_timeout");
    chk("t6_pre_outst", bus.outstanding, 3);
    chk("t6_pre_bid", bus.bid, 4'h1);
`ifdef WR_RESP_BUSER_EN
    chk("t6_pre_buser", bus.buser, 2'b10);
`endif
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_bvalid", bus.bvalid, 0);
    chk("t6_rst_outst", bus.outstanding, 0);
    chk("t6_rst_awready", bus.awready, 0);
    sb.delete();
    tick();
    tick();
    rst = 1'b0;
    bus.bready = 1'b1;
    tick();
    @(negedge clk);
    chk("t6_post_awready", bus.awready, 1);
    chk("t6_post_wready", bus.wready, 0);
    stale = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.bvalid) stale++;
      tick();
    end
    chk("t6_no_stale", stale, 0);
    chk("final_sb_empty", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
